// File: rtl/relu.sv
// Single-precision IEEE-754 ReLU / ReLU-derivative unit.
// Three-state handshake: capture operand, classify, publish a registered result.
module relu #(
  parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] x_data,
  input  logic        deriv,
  output logic [31:0] z_data,
  output logic        done
);

  localparam logic [31:0] ONE_F  = 32'h3F800000;
  localparam logic [31:0] ZERO_F = 32'h00000000;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic        deriv_q, deriv_d;
  logic [31:0] res_q, res_d;
  logic [31:0] z_q, z_d;
  logic        done_q, done_d;

  logic        sign_w;
  logic        is_nan_w;
  logic        is_zero_w;
  logic [31:0] result_w;

  assign sign_w    = x_q[31];
  assign is_nan_w  = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
  assign is_zero_w = (x_q[30:0] == 31'd0);

  // Sign is never forwarded, so -0 collapses to +0; derivative at zero is 0.
  always_comb begin
    result_w = ZERO_F;
    if (is_nan_w) begin
      result_w = NAN_OUT;
    end else if (!deriv_q) begin
      result_w = sign_w ? ZERO_F : x_q;
    end else begin
      result_w = (!sign_w && !is_zero_w) ? ONE_F : ZERO_F;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    deriv_d = deriv_q;
    res_d   = res_q;
    z_d     = z_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy) begin
          x_d     = x_data;
          deriv_d = deriv;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = result_w;
        state_d = DONE;
      end
      DONE: begin
        z_d     = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 32'd0;
      deriv_q <= 1'b0;
      res_q   <= 32'd0;
      z_q     <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      deriv_q <= deriv_d;
      res_q   <= res_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign z_data = z_q;
  assign done   = done_q;

endmodule

// File: tb/tb_relu.sv
// Self-checking bench for relu: transaction-level reference model plus
// directed vectors with literal expected results.
module tb_relu;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] x_data;
  logic        deriv;
  logic [31:0] z_data;
  logic        done;

  int checks = 0;
  int errors = 0;

  relu #(.NAN_OUT(32'h7FC00000)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .x_data (x_data),
    .deriv  (deriv),
    .z_data (z_data),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference function straight from the IEEE field rules.
  function automatic logic [31:0] relu_model(input logic [31:0] x, input logic d);
    logic nan;
    logic pos_nonzero;
    nan         = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    pos_nonzero = !x[31] && (x[30:0] != 0);
    if (nan) return 32'h7FC00000;
    if (!d)  return x[31] ? 32'h0 : x;
    return pos_nonzero ? 32'h3F800000 : 32'h0;
  endfunction

  // Transaction model: a capture produces its result two edges later.
  int          busy = 0;
  logic [31:0] pend = '0;
  logic [31:0] exp_z = '0;
  logic        exp_done = 1'b0;
  bit          model_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      busy        = 0;
      exp_z       = 32'h0;
      exp_done    = 1'b0;
      model_valid = 1;
    end else if (busy == 0) begin
      exp_done = 1'b0;
      if (rdy) begin
        pend = relu_model(x_data, deriv);
        busy = 2;
      end
    end else begin
      busy = busy - 1;
      if (busy == 0) begin
        exp_z    = pend;
        exp_done = 1'b1;
      end else begin
        exp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if (done !== exp_done || z_data !== exp_z) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: done=%b z=%h, expected done=%b z=%h",
                 $time, done, z_data, exp_done, exp_z);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One transaction; operands are scrambled right after capture.
  task automatic run_txn(input string name, input logic [31:0] x, input logic d,
                         input logic [31:0] expv);
    bit seen;
    seen = 0;
    @(negedge clk);
    x_data = x; deriv = d; rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; x_data = $urandom; deriv = ~d;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no done within 6 cycles, expected z=%h", name, expv);
    end else begin
      check_lit(name, z_data, expv);
      $display("txn %-12s x=%h deriv=%b -> z=%h (expected %h)", name, x, d, z_data, expv);
    end
  endtask

  initial begin
    int ndone;
    rst = 1'b1; rdy = 1'b1; x_data = 32'hDEADBEEF; deriv = 1'b0;

    // Pin the model itself against hand-computed values.
    check_lit("model_fwd_pos", relu_model(32'h410547AE, 1'b0), 32'h410547AE);
    check_lit("model_drv_neg", relu_model(32'hC0E80000, 1'b1), 32'h00000000);
    check_lit("model_nan", relu_model(32'h7FC12345, 1'b1), 32'h7FC00000);

    repeat (2) @(negedge clk);
    check_lit("reset_z", z_data, 32'h0);
    check_lit("reset_done", {31'd0, done}, 32'd0);

    // Release reset with rdy held: done on the third edge, then every third.
    rst = 1'b0; x_data = 32'h410547AE; deriv = 1'b1;
    @(negedge clk); check_lit("post_rst_e1_done", {31'd0, done}, 32'd0);
    @(negedge clk); check_lit("post_rst_e2_done", {31'd0, done}, 32'd0);
    @(negedge clk); check_lit("post_rst_e3_done", {31'd0, done}, 32'd1);
    check_lit("post_rst_z", z_data, 32'h3F800000);
    $display("txn %-12s x=%h deriv=1 -> z=%h", "first_drv", 32'h410547AE, z_data);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_lit("retrigger_count", ndone, 32'd2);
    $display("txn %-12s rdy held 6 cycles -> %0d done pulses", "retrigger", ndone);
    rdy = 1'b0;
    repeat (4) @(negedge clk);

    run_txn("drv_pos",    32'h410547AE, 1'b1, 32'h3F800000);
    run_txn("drv_neg",    32'hC0E80000, 1'b1, 32'h00000000);
    run_txn("fwd_pos",    32'h410547AE, 1'b0, 32'h410547AE);
    run_txn("fwd_neg",    32'hC0E80000, 1'b0, 32'h00000000);
    run_txn("fwd_negz",   32'h80000000, 1'b0, 32'h00000000);
    run_txn("fwd_denorm", 32'h00000001, 1'b0, 32'h00000001);
    run_txn("fwd_nan",    32'h7FC12345, 1'b0, 32'h7FC00000);
    run_txn("drv_nan",    32'h7FC12345, 1'b1, 32'h7FC00000);
    run_txn("drv_pinf",   32'h7F800000, 1'b1, 32'h3F800000);
    run_txn("fwd_ninf",   32'hFF800000, 1'b0, 32'h00000000);
    run_txn("drv_pz",     32'h00000000, 1'b1, 32'h00000000);
    run_txn("drv_nz",     32'h80000000, 1'b1, 32'h00000000);
    run_txn("fwd_pinf",   32'h7F800000, 1'b0, 32'h7F800000);
    run_txn("drv_denorm", 32'h00000001, 1'b1, 32'h3F800000);
    run_txn("fwd_snan",   32'hFF800001, 1'b0, 32'h7FC00000);

    // z_data holds between transactions.
    repeat (3) @(negedge clk);
    check_lit("hold_z", z_data, 32'h7FC00000);

    // Reset while the operation is in CALC: no done, z cleared.
    @(negedge clk);
    x_data = 32'h410547AE; deriv = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_lit("midrst_z", z_data, 32'h0);
    check_lit("midrst_done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_lit("midrst_no_done", ndone, 32'd0);
    $display("txn %-12s reset in CALC -> z=%h, %0d done pulses", "mid_reset", z_data, ndone);

    run_txn("after_rst", 32'h3F000000, 1'b0, 32'h3F000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
